// File: rtl/ntt_result_serializer.sv
// ntt_result_serializer
// Captures 16 parallel NTT result lanes in one cycle and streams them out,
// lane 0 first, one word per cycle over a valid/ready handshake.
module ntt_result_serializer #(
   parameter int                 P_WIDTH = 64,
   parameter logic [P_WIDTH-1:0] P_ZERO  = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_in,
   input  logic [P_WIDTH-1:0] Result0_in,
   input  logic [P_WIDTH-1:0] Result1_in,
   input  logic [P_WIDTH-1:0] Result2_in,
   input  logic [P_WIDTH-1:0] Result3_in,
   input  logic [P_WIDTH-1:0] Result4_in,
   input  logic [P_WIDTH-1:0] Result5_in,
   input  logic [P_WIDTH-1:0] Result6_in,
   input  logic [P_WIDTH-1:0] Result7_in,
   input  logic [P_WIDTH-1:0] Result8_in,
   input  logic [P_WIDTH-1:0] Result9_in,
   input  logic [P_WIDTH-1:0] Result10_in,
   input  logic [P_WIDTH-1:0] Result11_in,
   input  logic [P_WIDTH-1:0] Result12_in,
   input  logic [P_WIDTH-1:0] Result13_in,
   input  logic [P_WIDTH-1:0] Result14_in,
   input  logic [P_WIDTH-1:0] Result15_in,
   output logic               load_ready_out,
   output logic [P_WIDTH-1:0] data_out,
   output logic               valid_out,
   input  logic               ready_in,
   output logic [3:0]         index_out,
   output logic               last_out,
   output logic               done_out
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   localparam logic [3:0] LAST_LANE = 4'd15;

   state_t             state_q, state_d;
   logic [3:0]         index_q, index_d;
   logic               done_q, done_d;
   logic               capture;
   logic [P_WIDTH-1:0] lane [16];
   logic [P_WIDTH-1:0] mem  [16];

   // Gather the individual lane ports into an indexable array.
   assign lane[0]  = Result0_in;
   assign lane[1]  = Result1_in;
   assign lane[2]  = Result2_in;
   assign lane[3]  = Result3_in;
   assign lane[4]  = Result4_in;
   assign lane[5]  = Result5_in;
   assign lane[6]  = Result6_in;
   assign lane[7]  = Result7_in;
   assign lane[8]  = Result8_in;
   assign lane[9]  = Result9_in;
   assign lane[10] = Result10_in;
   assign lane[11] = Result11_in;
   assign lane[12] = Result12_in;
   assign lane[13] = Result13_in;
   assign lane[14] = Result14_in;
   assign lane[15] = Result15_in;

   // Next-state logic: capture in IDLE, advance the lane index on each handshake.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      index_d = index_q;
      done_d  = 1'b0;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_in) begin
               capture = 1'b1;
               index_d = 4'd0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (ready_in) begin
               if (index_q == LAST_LANE) begin
                  state_d = S_IDLE;
                  index_d = 4'd0;
                  done_d  = 1'b1;
               end else begin
                  index_d = index_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers; reset aborts any stream in progress immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         index_q <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         index_q <= index_d;
         done_q  <= done_d;
      end
   end

   // Capture buffer: written only on the capture edge, held otherwise.
   always_ff @(posedge clk) begin
      // NOTE: the buffer has no reset; stale contents are hidden behind valid_out.
      if (capture) begin
         for (int k = 0; k < 16; k++) begin
            mem[k] <= lane[k];
         end
      end
   end

   // Outputs decode registered state only; no input reaches an output combinationally.
   assign load_ready_out = (state_q == S_IDLE);
   assign valid_out      = (state_q == S_STREAM);
   assign data_out       = valid_out ? mem[index_q] : P_ZERO;
   assign index_out      = index_q;
   assign last_out       = valid_out && (index_q == LAST_LANE);
   assign done_out       = done_q;

endmodule

// File: tb/tb_ntt_result_serializer.sv
// Self-checking bench for ntt_result_serializer: a table-driven basic stream,
// hand-written corner sequences, and randomized traffic against a queue model.
module tb_ntt_result_serializer;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load = 1'b0;
   logic          ready = 1'b0;
   logic [W-1:0]  lanes [16];
   logic          load_ready;
   logic [W-1:0]  data;
   logic          valid;
   logic [3:0]    index;
   logic          last;
   logic          done;

   int errors = 0;
   int checks = 0;

   // Reference model: words still owed to the consumer, plus the done pulse.
   logic [W-1:0]  mq [$];
   bit            m_done = 1'b0;

   typedef struct {
      bit          load;
      bit          ready;
      bit          e_valid;
      logic [63:0] e_data;
      logic [3:0]  e_index;
      bit          e_last;
      bit          e_done;
      bit          e_lready;
   } vec_t;

   vec_t tbl [18];

   always #5 clk = ~clk;

   ntt_result_serializer #(.P_WIDTH(W), .P_ZERO('0)) dut (
      .clk(clk), .rst_n(rst_n), .load_in(load),
      .Result0_in(lanes[0]),   .Result1_in(lanes[1]),   .Result2_in(lanes[2]),
      .Result3_in(lanes[3]),   .Result4_in(lanes[4]),   .Result5_in(lanes[5]),
      .Result6_in(lanes[6]),   .Result7_in(lanes[7]),   .Result8_in(lanes[8]),
      .Result9_in(lanes[9]),   .Result10_in(lanes[10]), .Result11_in(lanes[11]),
      .Result12_in(lanes[12]), .Result13_in(lanes[13]), .Result14_in(lanes[14]),
      .Result15_in(lanes[15]),
      .load_ready_out(load_ready), .data_out(data), .valid_out(valid),
      .ready_in(ready), .index_out(index), .last_out(last), .done_out(done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_lanes(input logic [63:0] base);
      for (int k = 0; k < 16; k++) lanes[k] = base + 64'(k);
   endtask

   task automatic model_reset();
      mq.delete();
      m_done = 1'b0;
   endtask

   // One clock edge of the reference: capture when empty, pop on ready.
   task automatic model_edge();
      bit pop_last;
      pop_last = (mq.size() == 1) && ready;
      if (mq.size() == 0) begin
         if (load) for (int k = 0; k < 16; k++) mq.push_back(lanes[k]);
      end else if (ready) begin
         void'(mq.pop_front());
      end
      m_done = pop_last;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      int n;
      n = mq.size();
      check({tag, ".valid"}, valid, (n != 0));
      check({tag, ".data"}, data, (n != 0) ? mq[0] : 64'd0);
      check({tag, ".index"}, index, (n != 0) ? 64'(16 - n) : 64'd0);
      check({tag, ".last"}, last, (n == 1));
      check({tag, ".load_ready"}, load_ready, (n == 0));
      check({tag, ".done"}, done, m_done);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".valid"}, valid, 0);
      check({tag, ".data"}, data, 0);
      check({tag, ".index"}, index, 0);
      check({tag, ".last"}, last, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".load_ready"}, load_ready, 1);
   endtask

   // Stream out whatever remains with ready held high, bounded by a cycle budget.
   task automatic drain(input string tag);
      load  = 1'b0;
      ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         check_model(tag);
         if (m_done) return;
      end
      check({tag, ".timeout"}, 0, 1);
   endtask

   initial begin
      int hs;
      bit seen_done;
      bit bp_pat [4];

      // Reset held for three cycles.
      set_lanes(64'h1000);
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset_hold");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("reset_release");

      // Basic capture and full-rate stream, from a table of expected outputs.
      for (int i = 0; i < 18; i++) begin
         tbl[i].load     = (i == 0);
         tbl[i].ready    = 1'b1;
         tbl[i].e_valid  = (i < 16);
         tbl[i].e_data   = (i < 16) ? 64'h1000 + 64'(i) : 64'd0;
         tbl[i].e_index  = (i < 16) ? 4'(i) : 4'd0;
         tbl[i].e_last   = (i == 15);
         tbl[i].e_done   = (i == 16);
         tbl[i].e_lready = (i >= 16);
      end
      for (int i = 0; i < 18; i++) begin
         load  = tbl[i].load;
         ready = tbl[i].ready;
         tick();
         check($sformatf("tbl[%0d].valid", i), valid, tbl[i].e_valid);
         check($sformatf("tbl[%0d].data", i), data, tbl[i].e_data);
         check($sformatf("tbl[%0d].index", i), index, tbl[i].e_index);
         check($sformatf("tbl[%0d].last", i), last, tbl[i].e_last);
         check($sformatf("tbl[%0d].done", i), done, tbl[i].e_done);
         check($sformatf("tbl[%0d].load_ready", i), load_ready, tbl[i].e_lready);
      end
      load = 1'b0;

      // Backpressure: ready follows 1,0,0,1 repeating.
      bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      set_lanes(64'h2000);
      load  = 1'b1;
      ready = 1'b0;
      tick();
      check_model("bp_load");
      load = 1'b0;
      hs = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 80 && !seen_done; c++) begin
         ready = bp_pat[c % 4];
         if (mq.size() != 0 && ready) hs++;
         tick();
         check_model("bp");
         seen_done = m_done;
      end
      check("bp.done_seen", seen_done, 1);
      check("bp.handshakes", hs, 16);

      // Load during stream is ignored; load in the done cycle captures.
      set_lanes(64'h3000);
      load = 1'b1;
      tick();
      check_model("lds_load");
      ready = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         if (mq.size() == 11) begin
            set_lanes(64'h4000);
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
         tick();
         check_model("lds");
         seen_done = m_done;
      end
      check("lds.done_seen", seen_done, 1);
      set_lanes(64'h5000);
      load = 1'b1;
      tick();
      check_model("lds_reload");
      check("lds_reload.data", data, 64'h5000);
      drain("lds_drain");

      // Load coincident with the final handshake is ignored.
      set_lanes(64'h6000);
      load = 1'b1;
      tick();
      load  = 1'b0;
      ready = 1'b1;
      repeat (15) begin
         tick();
         check_model("col_stream");
      end
      check("col.last_before", last, 1);
      set_lanes(64'h7000);
      load = 1'b1;
      tick();
      check_model("col_edge");
      check("col.valid_after", valid, 0);
      load = 1'b0;
      tick();
      check_model("col_after");

      // Asynchronous reset in the middle of a stream at lane 9.
      set_lanes(64'h8000);
      load = 1'b1;
      tick();
      load  = 1'b0;
      ready = 1'b1;
      repeat (9) tick();
      check_model("rst_pre");
      check("rst_pre.index", index, 9);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_values("rst_async");
      @(negedge clk);
      check_reset_values("rst_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("rst_after");
      set_lanes(64'h9000);
      load = 1'b1;
      tick();
      check_model("rst_reload");
      check("rst_reload.data", data, 64'h9000);
      drain("rst_drain");

      // Idle bus activity with no load.
      load = 1'b0;
      repeat (10) begin
         for (int k = 0; k < 16; k++) lanes[k] = {$urandom, $urandom};
         tick();
         check_model("idle_bus");
      end

      // Randomized traffic against the queue model.
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < 16; k++) lanes[k] = {$urandom, $urandom};
         load  = ($urandom_range(0, 3) == 0);
         ready = ($urandom_range(0, 2) != 0);
         tick();
         check_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ntt_result_serializer.md
# ntt_result_serializer

Parallel-to-serial unloader on the result side of the NTT datapath. It captures the 16 lanes of `P_WIDTH`-bit result words from the NTT output stage in a single cycle. It then streams them one word per cycle, lane 0 first, to a downstream consumer over a valid/ready handshake. It is the consumer end of the 16-lane result bus and the bridge to the word-serial memory/host interface.

## Interface
Parameters:
- `P_WIDTH`, 64, width of one result word.
- `P_ZERO`, 64'h0, value driven on `data_out` when not valid; must be `P_WIDTH` bits.

Ports:
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `load_in`  input  1  capture strobe; sampled only while `load_ready_out`=1.
- `Result0_in` … `Result15_in`  input  `P_WIDTH` each  16 parallel result lanes; sampled on the `clk` edge where `load_in`=1 and `load_ready_out`=1.
- `load_ready_out`  output  1  1 when the block can accept a capture (state IDLE).
- `data_out`  output  `P_WIDTH`  current word; `P_ZERO` when `valid_out`=0.
- `valid_out`  output  1  `data_out` is valid.
- `ready_in`  input  1  downstream accepts `data_out` this cycle.
- `index_out`  output  4  lane number of the current word (0–15).
- `last_out`  output  1  1 while presenting lane 15 (`valid_out`=1 and `index_out`=15).
- `done_out`  output  1  one-cycle pulse the cycle after lane 15 is accepted.

## Operation
- Storage: 16 × `P_WIDTH` capture buffer, 4-bit index counter, 1-bit state.
- The buffer is not reset. Visibility is gated by `valid_out`.
- States: IDLE and STREAM.
- IDLE:
  - `load_ready_out`=1, `valid_out`=0.
  - On `load_in`=1, write all 16 lanes into the buffer, set index to 0, go to STREAM.
- STREAM:
  - `load_ready_out`=0, `valid_out`=1, `data_out` = buffer[index].
  - A handshake is `valid_out & ready_in` at a clock edge. On a handshake with index<15: index+1, stay in STREAM.
  - On a handshake with index=15: go to IDLE, index to 0, `done_out`=1 for the next cycle only.
  - With `ready_in`=0: hold index, `data_out`, `valid_out` and `last_out` stable (AXI-style: valid never drops without a handshake).
- `load_in` in STREAM is ignored; the buffer is not overwritten and no error is flagged.
- `load_in` coincident with the final handshake is ignored, because `load_ready_out` is 0 in that cycle. The earliest next capture is the following cycle.
- `Result*_in` is not registered outside the capture cycle; changes on the bus during STREAM have no effect.
- No arithmetic on data: words pass bit-exact. The index wraps 15→0 only via the transition to IDLE.

## Timing
- Reset values (while `rst_n`=0 and after release):
  - state IDLE, index 0;
  - `load_ready_out`=1, `valid_out`=0, `data_out`=`P_ZERO`, `index_out`=0, `last_out`=0, `done_out`=0.
- Reset mid-stream: the stream aborts immediately (asynchronously). The remaining words are lost; `done_out` is not pulsed.
- Latency:
  - Capture at edge N → `valid_out`=1 with lane 0 in cycle N+1.
  - With `ready_in` held 1, lanes 0..15 appear in cycles N+1..N+16.
  - `done_out`=1 in cycle N+17, and `load_ready_out`=1 from cycle N+17.
- Throughput: at most one block per 17 cycles.
- `done_out` and `load_ready_out` both rise in the same cycle after the final handshake.
- All outputs derive from registers only. There is no combinational path from `ready_in` or `load_in` to any output.

## Test plan
- Reset then capture: hold `rst_n`=0 for 3 cycles, release, pulse `load_in` with `ResultK_in`=64'h1000+K, `ready_in`=1 → words 64'h1000..64'h100F on consecutive cycles, `index_out` 0..15, `last_out` only with 64'h100F, `done_out` pulse 1 cycle later.
- Backpressure: same load, `ready_in` toggles 1,0,0,1,… → each word is held stable while `ready_in`=0, with no skips or duplicates. 16 handshakes total, then `done_out`.
- Load during stream: a second `load_in` with different data at index 5 → it is ignored and the original 16 words complete. A `load_in` in the cycle after `done_out` captures new data.
- Final-handshake collision: `load_in`=1 in the same cycle as the lane-15 handshake → ignored; `valid_out`=0 in the next cycle.
- Async reset mid-stream: assert `rst_n`=0 between edges at index 9 → outputs go to reset values immediately and `done_out` stays 0. After release, a new capture streams from lane 0.
- Idle bus activity: change `Result*_in` every cycle with `load_in`=0 → `valid_out` stays 0 and `data_out` stays `P_ZERO`.
